// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: word, half and byte loads/stores over a byte-wide
// asynchronous SRAM. One SRAM cycle per byte, then a one-cycle DONE completion.
module mem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] bus,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_size,
  input  logic        mem_addr_ready,
  output logic        mem_data_ready,
  output logic        mem_bus,
  output logic [31:0] mem_out,
  output logic        busy,
  output logic [18:0] sram_addr,
  output logic [7:0]  sram_wdata,
  input  logic [7:0]  sram_rdata,
  output logic        sram_cs,
  output logic        sram_oe,
  output logic        sram_we
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic [3:0]  size_reg;
  logic        write_reg;
  logic [1:0]  idx_reg;
  logic [1:0]  last_reg;

  logic [1:0]  last_idx;
  logic [31:0] assembled;
  logic [31:0] extended;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[31:19];

  always_comb begin
    if (mem_size[3] || mem_size[2])
      last_idx = 2'd0;
    else if (mem_size[1] || mem_size[0])
      last_idx = 2'd1;
    else
      last_idx = 2'd3;
  end

  // The byte arriving this cycle is merged here so the final byte can be
  // extended and presented without an extra cycle.
  always_comb begin
    assembled = rdata_reg;
    assembled[{idx_reg, 3'b000} +: 8] = sram_rdata;
  end

  always_comb begin
    extended = assembled;
    if (size_reg[3])
      extended = {{24{assembled[7]}}, assembled[7:0]};
    else if (size_reg[2])
      extended = {24'd0, assembled[7:0]};
    else if (size_reg[1])
      extended = {{16{assembled[15]}}, assembled[15:0]};
    else if (size_reg[0])
      extended = {16'd0, assembled[15:0]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      wdata_reg      <= 32'd0;
      rdata_reg      <= 32'd0;
      size_reg       <= 4'd0;
      write_reg      <= 1'b0;
      idx_reg        <= 2'd0;
      last_reg       <= 2'd0;
      mem_data_ready <= 1'b0;
      mem_bus        <= 1'b0;
      mem_out        <= 32'd0;
      busy           <= 1'b0;
      sram_addr      <= 19'd0;
      sram_wdata     <= 8'd0;
      sram_cs        <= 1'b0;
      sram_oe        <= 1'b0;
      sram_we        <= 1'b0;
    end else begin
      mem_data_ready <= 1'b0;
      mem_bus        <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_addr_ready && (mem_read || mem_write)) begin
            state      <= XFER;
            busy       <= 1'b1;
            write_reg  <= mem_write && !mem_read;
            size_reg   <= mem_size;
            last_reg   <= last_idx;
            idx_reg    <= 2'd0;
            wdata_reg  <= bus;
            rdata_reg  <= 32'd0;
            sram_addr  <= addr[18:0];
            sram_wdata <= bus[7:0];
            sram_cs    <= 1'b1;
            sram_oe    <= mem_read;
            sram_we    <= !mem_read;
          end
        end
        XFER: begin
          if (!mem_addr_ready) begin
            // Control withdrew the request: drop everything, no completion.
            state   <= IDLE;
            busy    <= 1'b0;
            sram_cs <= 1'b0;
            sram_oe <= 1'b0;
            sram_we <= 1'b0;
          end else begin
            rdata_reg <= assembled;
            if (idx_reg == last_reg) begin
              state          <= DONE;
              sram_cs        <= 1'b0;
              sram_oe        <= 1'b0;
              sram_we        <= 1'b0;
              mem_data_ready <= 1'b1;
              if (!write_reg) begin
                mem_bus <= 1'b1;
                mem_out <= extended;
              end
            end else begin
              idx_reg    <= idx_reg + 2'd1;
              sram_addr  <= sram_addr + 19'd1;
              sram_wdata <= wdata_reg[{idx_reg + 2'd1, 3'b000} +: 8];
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed cases plus random loads/stores checked cycle by
// cycle against a byte-array reference of the SRAM contents.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] bus = 32'd0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_size = 4'd0;
  logic        mem_addr_ready = 1'b0;
  logic        mem_data_ready;
  logic        mem_bus;
  logic [31:0] mem_out;
  logic        busy;
  logic [18:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_rdata;
  logic        sram_cs;
  logic        sram_oe;
  logic        sram_we;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_hold = 32'd0;

  logic [7:0] sram_arr [0:524287];
  logic [7:0] ref_mem  [0:524287];

  mem_ctrl dut (
    .clk(clk), .reset(reset), .addr(addr), .bus(bus),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_addr_ready(mem_addr_ready), .mem_data_ready(mem_data_ready),
    .mem_bus(mem_bus), .mem_out(mem_out), .busy(busy),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we)
  );

  always #5 clk = ~clk;

  // Asynchronous byte SRAM: combinational read, write committed at the edge.
  assign sram_rdata = sram_arr[sram_addr];
  always @(posedge clk)
    if (sram_cs && sram_we) sram_arr[sram_addr] <= sram_wdata;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [3:0] sz);
    if (sz[3] || sz[2]) return 1;
    if (sz[1] || sz[0]) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [18:0] base, input logic [3:0] sz);
    logic [31:0] raw;
    raw = 32'd0;
    for (int i = 0; i < nbytes(sz); i++)
      raw = raw | (32'(ref_mem[(int'(base) + i) % 524288]) << (8 * i));
    if (sz[3]) return raw[7] ? (raw | 32'hFFFFFF00) : raw;
    if (sz[2]) return raw;
    if (sz[1]) return raw[15] ? (raw | 32'hFFFF0000) : raw;
    return raw;
  endfunction

  task automatic preload(input int a, input logic [7:0] b);
    sram_arr[a] = b;
    ref_mem[a]  = b;
  endtask

  // One request from IDLE. abort_at / reset_at name the XFER byte index during
  // which mem_addr_ready or reset is pulled low (-1 = never).
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sz,
                        input logic rd, input logic wr, input int abort_at, input int reset_at);
    int n;
    logic is_wr;
    logic [18:0] base;
    logic [31:0] exp_rd;
    n = nbytes(sz);
    is_wr = wr && !rd;
    base = a[18:0];
    exp_rd = ref_read(base, sz);
    addr = a; bus = d; mem_size = sz; mem_read = rd; mem_write = wr; mem_addr_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      check("xfer_busy", 32'(busy), 32'd1);
      check("xfer_cs", 32'(sram_cs), 32'd1);
      check("xfer_oe", 32'(sram_oe), 32'(!is_wr));
      check("xfer_we", 32'(sram_we), 32'(is_wr));
      check("xfer_addr", 32'(sram_addr), 32'((int'(base) + i) % 524288));
      check("xfer_rdy", 32'(mem_data_ready), 32'd0);
      check("xfer_bus", 32'(mem_bus), 32'd0);
      if (is_wr) begin
        check("xfer_wdata", 32'(sram_wdata), 32'(d[8*i +: 8]));
        ref_mem[(int'(base) + i) % 524288] = d[8*i +: 8];
      end
      if (i == abort_at) mem_addr_ready = 1'b0;
      if (i == reset_at) reset = 1'b0;
      @(posedge clk); #1;
      if (i == abort_at || i == reset_at) begin
        mem_addr_ready = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reset = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_strobes", {29'd0, sram_cs, sram_oe, sram_we}, 32'd0);
        check("abort_rdy", 32'(mem_data_ready), 32'd0);
        check("abort_bus", 32'(mem_bus), 32'd0);
        if (i == reset_at) begin
          exp_hold = 32'd0;
          check("rst_sram_addr", 32'(sram_addr), 32'd0);
          check("rst_sram_wdata", 32'(sram_wdata), 32'd0);
        end
        check("abort_out_hold", mem_out, exp_hold);
        @(posedge clk); #1;
        check("post_abort_rdy", 32'(mem_data_ready), 32'd0);
        check("post_abort_busy", 32'(busy), 32'd0);
        $display("req addr=%h size=%b rd=%0d wr=%0d aborted at byte %0d%s", base, sz, rd, wr, i,
                 (i == reset_at) ? " by reset" : "");
        return;
      end
    end
    if (!is_wr) exp_hold = exp_rd;
    check("done_rdy", 32'(mem_data_ready), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_bus", 32'(mem_bus), 32'(!is_wr));
    check("done_strobes", {29'd0, sram_cs, sram_oe, sram_we}, 32'd0);
    check("done_out", mem_out, exp_hold);
    mem_addr_ready = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    check("idle_rdy", 32'(mem_data_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_bus", 32'(mem_bus), 32'd0);
    check("idle_out_hold", mem_out, exp_hold);
    $display("req addr=%h size=%b rd=%0d wr=%0d data=%h -> mem_out=%h", base, sz, rd, wr, d, mem_out);
  endtask

  initial begin
    logic [3:0] sz_tab [0:5];
    logic [3:0] sz;
    logic rd, wr;
    logic [31:0] a;
    int ab;
    sz_tab[0] = 4'b0000; sz_tab[1] = 4'b1000; sz_tab[2] = 4'b0100;
    sz_tab[3] = 4'b0010; sz_tab[4] = 4'b0001; sz_tab[5] = 4'b0000;
    for (int i = 0; i < 524288; i++) preload(i, 8'($urandom));
    preload(32'h100, 8'h11); preload(32'h101, 8'h22); preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'h205, 8'h80); preload(32'h10, 8'h34); preload(32'h11, 8'hF2);
    for (int i = 0; i < 4; i++) preload(32'h300 + i, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {26'd0, mem_data_ready, mem_bus, busy, sram_cs, sram_oe, sram_we}, 32'd0);
    check("rst_mem_out", mem_out, 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_sram_wdata", 32'(sram_wdata), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    do_req(32'h100, 32'h0, 4'b0000, 1'b1, 1'b0, -1, -1);
    check("word_read", mem_out, 32'h44332211);
    do_req(32'h205, 32'h0, 4'b1000, 1'b1, 1'b0, -1, -1);
    check("lb", mem_out, 32'hFFFFFF80);
    do_req(32'h205, 32'h0, 4'b0100, 1'b1, 1'b0, -1, -1);
    check("lbu", mem_out, 32'h00000080);
    do_req(32'h10, 32'h0, 4'b0010, 1'b1, 1'b0, -1, -1);
    check("lh", mem_out, 32'hFFFFF234);
    do_req(32'h10, 32'h0, 4'b0001, 1'b1, 1'b0, -1, -1);
    check("lhu", mem_out, 32'h0000F234);
    do_req(32'h7FFFC, 32'hDEADBEEF, 4'b0000, 1'b0, 1'b1, -1, -1);
    check("sw_hold", mem_out, 32'h0000F234);
    do_req(32'h7FFFC, 32'h0, 4'b0000, 1'b1, 1'b0, -1, -1);
    check("sw_readback", mem_out, 32'hDEADBEEF);
    do_req(32'h100, 32'h0, 4'b0000, 1'b1, 1'b0, 2, -1);
    do_req(32'h101, 32'h0, 4'b0100, 1'b1, 1'b0, -1, -1);
    check("after_abort", mem_out, 32'h00000022);
    do_req(32'h200, 32'h12345678, 4'b1010, 1'b1, 1'b1, -1, -1);
    do_req(32'h300, 32'hCAFEF00D, 4'b0000, 1'b0, 1'b1, -1, 1);
    check("rst_mem_out_mid", mem_out, 32'd0);
    do_req(32'h300, 32'h0, 4'b0000, 1'b1, 1'b0, -1, -1);
    check("rst_two_bytes", mem_out, 32'h0000F00D);

    for (int t = 0; t < 60; t++) begin
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      sz = ($urandom_range(0, 7) == 0) ? 4'($urandom) : sz_tab[$urandom_range(0, 5)];
      a = ($urandom_range(0, 3) == 0) ? (32'($urandom) | 32'h0007FFFC) : 32'($urandom);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      do_req(a, 32'($urandom), sz, rd, wr, ab, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
